// File: rtl/zigbee_test_pkg.sv
// rtl/zigbee_test_pkg.sv - shared types and constants for the test-mux configuration controller
package zigbee_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_APPLY,
        ST_READ
    } state_t;

    localparam logic [3:0] CMD_WRITE = 4'hA;
    localparam logic [3:0] CMD_READ  = 4'h5;
    localparam logic [3:0] CMD_NOP   = 4'h0;

    localparam int FRAME_LEN = 18;
    localparam int PAYLOAD_W = 13;

    localparam int SEL1_LSB  = 10;
    localparam int SEL1_W    = 3;
    localparam int SEL6_LSB  = 8;
    localparam int SEL6_W    = 2;
    localparam int SEL9_LSB  = 6;
    localparam int SEL9_W    = 2;
    localparam int SEL11_LSB = 5;
    localparam int SEL11_W   = 1;
    localparam int SEL12_LSB = 4;
    localparam int SEL12_W   = 1;
    localparam int SEL15_LSB = 1;
    localparam int SEL15_W   = 3;
    localparam int SEL17_LSB = 0;
    localparam int SEL17_W   = 1;

endpackage

// File: rtl/test_cfg_ctrl.sv
// rtl/test_cfg_ctrl.sv - serial-framed test-mux select register block with parity check and readback
module test_cfg_ctrl
    import zigbee_test_pkg::*;
#(
    parameter int RB_ENABLE = 1
) (
    input  logic                inClock,
    input  logic                inReset,
    input  logic                inTestEnable,
    input  logic                inSerEnable,
    input  logic                inSerData,
    output logic [SEL1_W-1:0]   outSel1,
    output logic [SEL6_W-1:0]   outSel6,
    output logic [SEL9_W-1:0]   outSel9,
    output logic [SEL11_W-1:0]  outSel11,
    output logic [SEL12_W-1:0]  outSel12,
    output logic [SEL15_W-1:0]  outSel15,
    output logic [SEL17_W-1:0]  outSel17,
    output logic                outSerData,
    output logic                outSerValid,
    output logic                outBusy,
    output logic                outUpdated,
    output logic                outError
);

    localparam int         RB_LEN   = PAYLOAD_W + 1;
    localparam logic [4:0] LAST_BIT = 5'(FRAME_LEN - 1);
    localparam logic [3:0] LAST_RB  = 4'(RB_LEN - 1);

    state_t                 state_q, state_d;
    logic                   en_prev_q;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [FRAME_LEN-1:0]   frame_q, frame_d;
    logic [PAYLOAD_W-1:0]   cfg_q, cfg_d;
    logic [RB_LEN-1:0]      rd_sr_q, rd_sr_d;
    logic [3:0]             rd_cnt_q, rd_cnt_d;
    logic                   ser_data_q, ser_data_d;
    logic                   ser_valid_q, ser_valid_d;
    logic                   updated_q, updated_d;
    logic                   error_q, error_d;

    logic                   ser_rise;
    logic [3:0]             frame_cmd;
    logic [PAYLOAD_W-1:0]   frame_payload;
    logic                   parity_ok;
    logic                   cmd_is_write;
    logic                   cmd_is_read;
    logic                   cmd_known;

    assign ser_rise      = inSerEnable & ~en_prev_q;
    assign frame_cmd     = frame_q[FRAME_LEN-1 -: 4];
    assign frame_payload = frame_q[PAYLOAD_W:1];
    assign parity_ok     = ~(^frame_q);
    assign cmd_is_write  = (frame_cmd == CMD_WRITE);
    assign cmd_is_read   = (frame_cmd == CMD_READ) && (RB_ENABLE != 0);
    assign cmd_known     = cmd_is_write || cmd_is_read || (frame_cmd == CMD_NOP);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        cfg_d       = cfg_q;
        rd_sr_d     = rd_sr_q;
        rd_cnt_d    = rd_cnt_q;
        ser_data_d  = 1'b0;
        ser_valid_d = 1'b0;
        updated_d   = 1'b0;
        error_d     = error_q;

        case (state_q)
            ST_IDLE: begin
                if (ser_rise) begin
                    frame_d   = {frame_q[FRAME_LEN-2:0], inSerData};
                    bit_cnt_d = 5'd1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (inSerEnable) begin
                    frame_d = {frame_q[FRAME_LEN-2:0], inSerData};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = 5'd0;
                        state_d   = ST_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    // short frame: drop it and leave the selects alone
                    error_d   = 1'b1;
                    bit_cnt_d = 5'd0;
                    state_d   = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (ser_rise) begin
                    error_d = 1'b1;
                end
                if (!parity_ok || !cmd_known || (cmd_is_write && !inTestEnable)) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (cmd_is_write) begin
                    state_d = ST_APPLY;
                end else if (cmd_is_read) begin
                    rd_sr_d  = {cfg_q, ^cfg_q};
                    rd_cnt_d = 4'd0;
                    state_d  = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                cfg_d     = frame_payload;
                updated_d = 1'b1;
                error_d   = ser_rise;
                state_d   = ST_IDLE;
            end
            ST_READ: begin
                ser_data_d  = rd_sr_q[RB_LEN-1];
                ser_valid_d = 1'b1;
                rd_sr_d     = {rd_sr_q[RB_LEN-2:0], 1'b0};
                if (ser_rise) begin
                    error_d = 1'b1;
                end
                if (rd_cnt_q == LAST_RB) begin
                    rd_cnt_d = 4'd0;
                    state_d  = ST_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // test disable forces mission mode and reports the drop once
        if (!inTestEnable) begin
            cfg_d     = '0;
            updated_d = (cfg_q != '0);
        end
    end

    always_ff @(posedge inClock) begin
        if (inReset) begin
            state_q     <= ST_IDLE;
            en_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            cfg_q       <= '0;
            rd_sr_q     <= '0;
            rd_cnt_q    <= '0;
            ser_data_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            updated_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_prev_q   <= inSerEnable;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            cfg_q       <= cfg_d;
            rd_sr_q     <= rd_sr_d;
            rd_cnt_q    <= rd_cnt_d;
            ser_data_q  <= ser_data_d;
            ser_valid_q <= ser_valid_d;
            updated_q   <= updated_d;
            error_q     <= error_d;
        end
    end

    assign outSel1     = cfg_q[SEL1_LSB  +: SEL1_W];
    assign outSel6     = cfg_q[SEL6_LSB  +: SEL6_W];
    assign outSel9     = cfg_q[SEL9_LSB  +: SEL9_W];
    assign outSel11    = cfg_q[SEL11_LSB +: SEL11_W];
    assign outSel12    = cfg_q[SEL12_LSB +: SEL12_W];
    assign outSel15    = cfg_q[SEL15_LSB +: SEL15_W];
    assign outSel17    = cfg_q[SEL17_LSB +: SEL17_W];
    assign outSerData  = ser_data_q;
    assign outSerValid = ser_valid_q;
    assign outBusy     = (state_q != ST_IDLE);
    assign outUpdated  = updated_q;
    assign outError    = error_q;

endmodule

// File: tb/tb_test_cfg_ctrl.sv
// tb/tb_test_cfg_ctrl.sv - randomized and directed checks of test_cfg_ctrl against a scheduled-event model
module tb_test_cfg_ctrl;

    localparam int TB_RB = 1;

    logic       clk;
    logic       inReset;
    logic       inTestEnable;
    logic       inSerEnable;
    logic       inSerData;
    logic [2:0] outSel1;
    logic [1:0] outSel6;
    logic [1:0] outSel9;
    logic       outSel11;
    logic       outSel12;
    logic [2:0] outSel15;
    logic       outSel17;
    logic       outSerData;
    logic       outSerValid;
    logic       outBusy;
    logic       outUpdated;
    logic       outError;

    test_cfg_ctrl #(.RB_ENABLE(TB_RB)) dut (
        .inClock      (clk),
        .inReset      (inReset),
        .inTestEnable (inTestEnable),
        .inSerEnable  (inSerEnable),
        .inSerData    (inSerData),
        .outSel1      (outSel1),
        .outSel6      (outSel6),
        .outSel9      (outSel9),
        .outSel11     (outSel11),
        .outSel12     (outSel12),
        .outSel15     (outSel15),
        .outSel17     (outSel17),
        .outSerData   (outSerData),
        .outSerValid  (outSerValid),
        .outBusy      (outBusy),
        .outUpdated   (outUpdated),
        .outError     (outError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [12:0] dut_cfg;
    assign dut_cfg = {outSel1, outSel6, outSel9, outSel11, outSel12, outSel15, outSel17};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [17:0] mk(input logic [3:0] c, input logic [12:0] p);
        mk = {c, p, ^{c, p}};
    endfunction

    // Model: frames collected as bit queues, outcomes scheduled at absolute edge numbers.
    longint      k        = 0;
    longint      check_at = -1;
    longint      apply_at = -1;
    bit          prev_en  = 0;
    bit          rx_on    = 0;
    bit          rx_bits[$];
    bit          out_bits[$];
    logic [12:0] pend_payload = '0;
    logic [12:0] m_cfg = '0;
    bit          m_upd = 0, m_err = 0, m_sd = 0, m_sv = 0, m_busy = 0;

    task automatic model_eval(input bit rise);
        logic [3:0]  cmd;
        logic [12:0] pay;
        int          ones;
        bit          wr, rd, known;
        ones = 0;
        foreach (rx_bits[i]) ones += rx_bits[i];
        for (int i = 0; i < 4; i++) cmd[3-i] = rx_bits[i];
        for (int i = 0; i < 13; i++) pay[12-i] = rx_bits[4+i];
        rx_bits.delete();
        wr    = (cmd == 4'hA);
        rd    = (cmd == 4'h5) && (TB_RB != 0);
        known = wr || rd || (cmd == 4'h0);
        if (rise) m_err = 1;
        if ((ones % 2) != 0 || !known || (wr && !inTestEnable)) begin
            m_err = 1;
        end else if (wr) begin
            apply_at     = k + 1;
            pend_payload = pay;
        end else if (rd) begin
            for (int i = 12; i >= 0; i--) out_bits.push_back(m_cfg[i]);
            out_bits.push_back(^m_cfg);
        end
    endtask

    task automatic model_step();
        bit          rise;
        logic [12:0] old_cfg;
        k++;
        if (inReset) begin
            rx_on = 0; rx_bits.delete(); out_bits.delete();
            check_at = -1; apply_at = -1; prev_en = 0;
            m_cfg = '0; m_upd = 0; m_err = 0; m_sd = 0; m_sv = 0; m_busy = 0;
            return;
        end
        rise    = inSerEnable && !prev_en;
        old_cfg = m_cfg;
        m_upd = 0; m_sd = 0; m_sv = 0;
        if (rx_on) begin
            if (inSerEnable) begin
                rx_bits.push_back(inSerData);
                if (rx_bits.size() == 18) begin
                    rx_on    = 0;
                    check_at = k + 1;
                end
            end else begin
                rx_on = 0;
                m_err = 1;
                rx_bits.delete();
            end
        end else if (k == check_at) begin
            model_eval(rise);
        end else if (k == apply_at) begin
            m_cfg = pend_payload;
            m_upd = 1;
            m_err = rise;
        end else if (out_bits.size() > 0) begin
            m_sd = out_bits.pop_front();
            m_sv = 1;
            if (rise) m_err = 1;
        end else if (rise) begin
            rx_on = 1;
            rx_bits.delete();
            rx_bits.push_back(inSerData);
        end
        if (!inTestEnable) begin
            m_upd = (old_cfg != 0);
            m_cfg = '0;
        end
        m_busy  = rx_on || (check_at == k + 1) || (apply_at == k + 1) || (out_bits.size() > 0);
        prev_en = inSerEnable;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("cfg", 32'(dut_cfg), 32'(m_cfg));
            check("flags", 32'({outUpdated, outError, outSerData, outSerValid, outBusy}),
                  32'({m_upd, m_err, m_sd, m_sv, m_busy}));
        end
    end

    task automatic send_bits(input logic [17:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            inSerEnable = 1'b1;
            inSerData   = f[17-i];
            @(negedge clk);
        end
        inSerEnable = 1'b0;
        inSerData   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [17:0] w_frame;
    logic [17:0] r_frame;
    logic [13:0] rb_exp;

    initial begin
        w_frame = 18'b1010_1011001101101_0;
        r_frame = 18'b0101_0000000000000_0;
        rb_exp  = 14'b1011001101101_0;
        inReset = 1'b1; inTestEnable = 1'b1; inSerEnable = 1'b0; inSerData = 1'b0;
        idle(3);
        check("rst_cfg", 32'(dut_cfg), 32'h0);
        check("rst_flags", 32'({outUpdated, outError, outSerData, outSerValid, outBusy}), 32'h0);
        inReset = 1'b0;
        idle(2);

        // bad parity
        send_bits(w_frame ^ 18'h1, 18);
        idle(1);
        check("par_err", 32'(outError), 32'h1);
        idle(1);
        check("par_cfg", 32'(dut_cfg), 32'h0);
        check("par_upd", 32'(outUpdated), 32'h0);

        // good write
        send_bits(w_frame, 18);
        idle(1);
        check("wr_busy_n1", 32'(outBusy), 32'h1);
        check("wr_cfg_n1", 32'(dut_cfg), 32'h0);
        idle(1);
        check("sel1", 32'(outSel1), 32'd5);
        check("sel6", 32'(outSel6), 32'd2);
        check("sel9", 32'(outSel9), 32'd1);
        check("sel11", 32'(outSel11), 32'd1);
        check("sel12", 32'(outSel12), 32'd0);
        check("sel15", 32'(outSel15), 32'd6);
        check("sel17", 32'(outSel17), 32'd1);
        check("wr_upd", 32'(outUpdated), 32'h1);
        check("wr_err_clr", 32'(outError), 32'h0);
        check("model_cfg", 32'(m_cfg), 32'h1_66D);
        idle(1);
        check("wr_upd_end", 32'(outUpdated), 32'h0);
        idle(2);

        // readback
        send_bits(r_frame, 18);
        idle(1);
        for (int i = 0; i < 14; i++) begin
            idle(1);
            check("rb_valid", 32'(outSerValid), 32'h1);
            check("rb_data", 32'(outSerData), 32'(rb_exp[13-i]));
        end
        idle(1);
        check("rb_valid_end", 32'(outSerValid), 32'h0);
        check("rb_busy_end", 32'(outBusy), 32'h0);
        idle(2);

        // aborted frame after 9 bits
        send_bits(w_frame, 9);
        idle(1);
        check("abort_err", 32'(outError), 32'h1);
        check("abort_busy", 32'(outBusy), 32'h0);
        check("abort_sel15", 32'(outSel15), 32'd6);
        idle(2);
        send_bits(mk(4'hA, 13'h0ABC), 18);
        idle(2);
        check("abort_clr", 32'(outError), 32'h0);
        check("abort_sel1", 32'(outSel1), 32'd2);
        idle(2);

        // reset at bit 12
        send_bits(w_frame, 12);
        inReset = 1'b1;
        idle(1);
        check("mid_rst_cfg", 32'(dut_cfg), 32'h0);
        check("mid_rst_flags", 32'({outUpdated, outError, outSerData, outSerValid, outBusy}), 32'h0);
        inReset = 1'b0;
        idle(4);
        check("mid_rst_noapply", 32'(dut_cfg), 32'h0);

        // test enable drop
        send_bits(mk(4'hA, 13'h000C), 18);
        idle(2);
        check("te_sel15", 32'(outSel15), 32'd6);
        idle(1);
        inTestEnable = 1'b0;
        idle(1);
        check("te_cfg0", 32'(dut_cfg), 32'h0);
        check("te_upd", 32'(outUpdated), 32'h1);
        idle(1);
        check("te_upd_end", 32'(outUpdated), 32'h0);
        send_bits(mk(4'hA, 13'h1FFF), 18);
        idle(1);
        check("te_wr_err", 32'(outError), 32'h1);
        idle(2);
        check("te_wr_cfg", 32'(dut_cfg), 32'h0);
        check("te_wr_upd", 32'(outUpdated), 32'h0);
        inTestEnable = 1'b1;
        idle(2);

        // randomized traffic, checked every cycle by the model
        for (int it = 0; it < 300; it++) begin
            int          r;
            logic [3:0]  c;
            logic [17:0] f;
            r = $urandom_range(0, 99);
            if (r < 55) begin
                case ($urandom_range(0, 3))
                    0: c = 4'hA;
                    1: c = 4'h5;
                    2: c = 4'h0;
                    default: c = 4'($urandom);
                endcase
                f = mk(c, 13'($urandom));
                if ($urandom_range(0, 9) == 0) f[0] = ~f[0];
                send_bits(f, 18);
                for (int e = $urandom_range(0, 2); e > 0; e--) begin
                    inSerEnable = 1'b1;
                    inSerData   = 1'($urandom);
                    idle(1);
                end
                inSerEnable = 1'b0;
            end else if (r < 65) begin
                send_bits(18'($urandom), $urandom_range(1, 17));
            end else if (r < 72) begin
                inTestEnable = (inTestEnable == 1'b0) ? 1'b1 : 1'($urandom_range(0, 1));
                idle(1);
            end else if (r < 80) begin
                idle($urandom_range(1, 6));
                inSerEnable = 1'b1;
                inSerData   = 1'($urandom);
                idle(1);
                inSerEnable = 1'b0;
            end else if (r < 83) begin
                inReset = 1'b1;
                idle($urandom_range(1, 2));
                inReset = 1'b0;
            end
            idle($urandom_range(0, 3));
        end
        inTestEnable = 1'b1;
        inSerEnable  = 1'b0;
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/test_cfg_ctrl.md
TEST_CFG_CTRL -- requirements
Module: test_cfg_ctrl

Interface
REQ-001 SHALL have parameter RB_ENABLE, default 1; 1 = READ command supported, 0 = READ treated as unknown command.
REQ-002 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 SHALL have port inClock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port inReset  input  1  synchronous active-high reset.
REQ-005 SHALL have port inTestEnable  input  1  1 = test configuration allowed.
REQ-006 SHALL have port inSerEnable  input  1  serial frame strobe, high for the whole frame.
REQ-007 SHALL have port inSerData  input  1  serial frame bit, MSB first, sampled when inSerEnable=1.
REQ-008 SHALL have ports outSel1 (3), outSel6 (2), outSel9 (2), outSel11 (1), outSel12 (1), outSel15 (3), outSel17 (1); all are outputs and are the test-mux select registers.
REQ-009 SHALL have port outSerData  output  1  readback bit.
REQ-010 SHALL have port outSerValid  output  1  readback bit valid.
REQ-011 SHALL have port outBusy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port outUpdated  output  1  one-cycle pulse when the selects change.
REQ-013 SHALL have port outError  output  1  sticky error flag.

Function
REQ-014 Frame format SHALL be 18 bits: CMD[3:0], PAYLOAD[12:0], PARITY.
- PARITY makes the total number of ones in the 18 bits even.
REQ-015 PAYLOAD mapping SHALL be: [12:10]=Sel1, [9:8]=Sel6, [7:6]=Sel9, [5]=Sel11, [4]=Sel12, [3:1]=Sel15, [0]=Sel17.
REQ-016 Commands SHALL be: 4'hA = WRITE, 4'h5 = READ, 4'h0 = NOP; all other codes are unknown.
REQ-017 FSM states SHALL be IDLE, SHIFT, CHECK, APPLY, READ.
REQ-018 In IDLE, a rising edge of inSerEnable SHALL start a frame.
- The bit sampled in that cycle is bit 0.
- State goes to SHIFT.
REQ-019 In SHIFT, one bit SHALL be sampled per cycle while inSerEnable=1.
- After the 18th bit, state goes to CHECK regardless of inSerEnable.
REQ-020 If inSerEnable falls before 18 bits, the frame SHALL be aborted.
- outError is set, the selects are unchanged, and state goes to IDLE.
REQ-021 Bits presented after the 18th, while inSerEnable stays high, SHALL be ignored.
- A new frame requires a fresh rising edge.
REQ-022 CHECK SHALL last one cycle and branch as follows:
- Parity failure, unknown command, or WRITE with inTestEnable=0 -> set outError, go to IDLE.
- Valid WRITE -> APPLY.
- Valid READ -> READ.
- NOP -> IDLE.
REQ-023 Timing of a WRITE, where the last bit is sampled at edge N:
- All selects SHALL update together at edge N+2.
- outUpdated is high for exactly the following cycle.
- outError is cleared.
REQ-024 READ SHALL shift out {active 13-bit config, even parity bit} MSB first, 14 cycles, with outSerValid=1 throughout; it then returns to IDLE.
REQ-025 A rising edge of inSerEnable during CHECK, APPLY or READ SHALL be ignored and SHALL set outError.
REQ-026 While inTestEnable=0, all select registers SHALL be held at 0; its falling edge produces an outUpdated pulse if any select was nonzero.
REQ-027 All selects = 0 SHALL be mission mode (functional path selected on every mux).

Reset
REQ-028 While inReset=1, the following SHALL hold at the next edge:
- State = IDLE.
- All selects = 0.
- outSerData, outSerValid, outBusy, outUpdated, outError = 0.
- Bit counter = 0.
REQ-029 Reset asserted mid-frame or mid-readback SHALL discard the operation with no partial select update.

Structure
REQ-030 Package zigbee_test_pkg SHALL hold:
- The state enum.
- The CMD_WRITE, CMD_READ and CMD_NOP constants.
- FRAME_LEN = 18 and PAYLOAD_W = 13.
- The payload field LSB/width constants.
REQ-031 The shifter and readback serializer SHALL be inline; no sub-module.

Verification
REQ-032 WRITE 1010_1011001101101_0 with inTestEnable=1 -> 2 cycles after the last bit:
- Sel1=5, Sel6=2, Sel9=1, Sel11=1, Sel12=0, Sel15=6, Sel17=1.
- One-cycle outUpdated pulse.
REQ-033 Same frame with the parity bit set to 1 -> outError=1, selects unchanged at 0, no outUpdated.
REQ-034 READ 0101_0000000000000_0 after REQ-032 -> outSerValid high for 14 cycles carrying 1011001101101 then 0.
REQ-035 inSerEnable dropped after 9 bits -> outError=1, state IDLE, selects unchanged.
- A subsequent valid WRITE clears outError.
REQ-036 Reset asserted at bit 12 of a WRITE -> all outputs 0 next cycle; the frame is not applied.
REQ-037 inTestEnable deasserted with Sel15=6 -> all selects 0 next cycle with outUpdated pulse.
- A subsequent WRITE sets outError and does not change the selects.
